// File: rtl/gate_sweep_checker.sv
// Exhaustive 2-input gate checker: drives {a,b} through 00..11, waits SETTLE cycles
// per vector, samples y against truth_tbl and reports a mismatch mask/count/pass.
module gate_sweep_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] truth_tbl,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] err_mask
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ab_q, ab_d;
    logic             busy_d, done_d, pass_d;
    logic [2:0]       err_count_d;
    logic [3:0]       err_mask_d;

    assign a = ab_q[1];
    assign b = ab_q[0];

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            ab_q      <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            err_mask  <= 4'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            ab_q      <= ab_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_count <= err_count_d;
            err_mask  <= err_mask_d;
        end
    end

    // Next-state and output logic; busy/done are registered alongside the state
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        ab_d        = ab_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        pass_d      = pass;
        err_count_d = err_count;
        err_mask_d  = err_mask;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d       = '0;
                    ab_d        = 2'b00;
                    cnt_d       = '0;
                    err_count_d = 3'd0;
                    err_mask_d  = 4'd0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_SETTLE;
                end
            end
            S_SETTLE: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (y != truth_tbl[idx_q]) begin
                    err_mask_d[idx_q] = 1'b1;
                    err_count_d       = err_count + 3'd1;
                end
                if (idx_q != IDX_W'(3)) begin
                    idx_d   = idx_q + IDX_W'(1);
                    ab_d    = idx_q + IDX_W'(1);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SETTLE;
                end else begin
                    pass_d  = (err_mask_d == 4'd0);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/gate_sweep_checker.md
GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 SHALL have parameter: SETTLE, 2, cycles {a,b} is held stable before y is sampled; legal range 1..15.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  sweep request; sampled on rising edge of clk.
REQ-005 SHALL have port: truth_tbl  input  4  expected y per vector; bit idx is the expected value for idx = {a,b}, with a as MSB.
REQ-006 SHALL have port: y  input  1  output of the 2-input gate under test.
REQ-007 SHALL have port: a  output  1  gate input A, registered.
REQ-008 SHALL have port: b  output  1  gate input B, registered.
REQ-009 SHALL have port: busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse at end of sweep.
REQ-011 SHALL have port: pass  output  1  sweep result, 1 = zero mismatches.
REQ-012 SHALL have port: err_count  output  3  number of mismatching vectors, 0..4.
REQ-013 SHALL have port: err_mask  output  4  bit idx set if vector idx mismatched.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-015 IDLE: start=1 at an edge SHALL be accepted, with the following effects at that edge:
- idx<=0, {a,b}<=2'b00, settle counter<=0.
- err_count<=0, err_mask<=0, pass<=0.
- state<=SETTLE.
REQ-016 start SHALL be ignored in SETTLE, SAMPLE and DONE; no queuing.
REQ-017 SETTLE: counter SHALL increment each edge; at the edge where counter==SETTLE-1, state SHALL go to SAMPLE.
REQ-018 SAMPLE: at the next edge, y SHALL be compared with truth_tbl[idx]; on mismatch, err_mask[idx]<=1 and err_count<=err_count+1.
REQ-019 SAMPLE with idx<3: at the same edge, idx<=idx+1, {a,b}<=idx+1, counter<=0, state<=SETTLE.
REQ-020 SAMPLE with idx==3: at the same edge, {a,b} SHALL hold 2'b11, pass<=(no mismatch across all four vectors including this one), state<=DONE.
REQ-021 DONE SHALL last exactly one cycle with done=1, then go to IDLE; idx SHALL not wrap beyond 3.
REQ-022 Vector order SHALL be 00, 01, 10, 11; each vector is driven for SETTLE+1 cycles.
REQ-023 Latency: the last sample SHALL occur 4*(SETTLE+1) edges after the start-accept edge; done SHALL be high in the following cycle.
REQ-024 busy SHALL be 1 in SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-025 pass, err_count and err_mask SHALL hold their values after DONE until the next start is accepted.
REQ-026 a and b SHALL hold their last values in IDLE.
REQ-027 truth_tbl SHALL be read only at SAMPLE edges; changes mid-sweep affect only later samples.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE, idx=0, counter=0.
- a=0, b=0.
- busy=0, done=0, pass=0, err_count=0, err_mask=0.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; the first edge after rst_n rises SHALL be treated as in IDLE.

Verification
REQ-030 Reset: drive rst_n=0 between edges -> all outputs 0 immediately, with no clock edge needed.
REQ-031 SETTLE=2, y from a NOR gate, truth_tbl=4'b0001, 1-cycle start pulse ->
- {a,b} = 00, 01, 10, 11, each held 3 cycles.
- done high in the cycle after edge 12.
- pass=1, err_count=0, err_mask=4'b0000.
REQ-032 NOR gate with truth_tbl=4'b1000 (AND table) -> err_mask=4'b1001, err_count=2, pass=0.
REQ-033 y tied to 1 with truth_tbl=4'b0001 -> err_mask=4'b1110, err_count=3, pass=0.
REQ-034 start held high for the whole run -> exactly one sweep per IDLE entry:
- second sweep accepted on the first edge back in IDLE.
- results cleared at that accept.
- busy=0 and done=1 for a single cycle between sweeps.
REQ-035 rst_n pulsed low while vector 10 is driven -> a=b=0, busy=0, no done pulse; a fresh start then completes a clean full sweep with pass=1 against NOR/4'b0001.
